// File: rtl/pixie_pkg.sv
// Shared types and helpers for the pixie video DMA front end and its timing generator.
package pixie_pkg;

    typedef enum logic [1:0] {
        SC_FETCH = 2'b00,
        SC_EXEC  = 2'b01,
        SC_DMA   = 2'b10,
        SC_INT   = 2'b11
    } sc_e;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_BLANK,
        ST_FETCH,
        ST_REPEAT
    } rep_state_e;

    localparam int unsigned REP_W = 3;

    // Last rep_cnt value of a row group: 1/2/4/8 scanlines per fetched row.
    function automatic logic [REP_W-1:0] rep_last(input logic [1:0] sel);
        logic [REP_W-1:0] r;
        case (sel)
            2'd0:    r = 3'd0;
            2'd1:    r = 3'd1;
            2'd2:    r = 3'd3;
            default: r = 3'd7;
        endcase
        return r;
    endfunction

    function automatic logic in_window(input int unsigned val, input int unsigned lo,
                                       input int unsigned hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/pixie_timing_gen.sv
// Horizontal/vertical counters and per-line efx/int/v_active flags, registered at
// line end so each flag describes the following scanline.
module pixie_timing_gen
    import pixie_pkg::*;
#(
    parameter int unsigned BYTES_PER_LINE  = 14,
    parameter int unsigned LINES_PER_FRAME = 262,
    parameter int unsigned ACTIVE_START    = 80,
    parameter int unsigned ACTIVE_LINES    = 128,
    parameter int unsigned INT_LINES       = 2,
    parameter int unsigned EFX_LINES       = 4,
    localparam int unsigned H_W = $clog2(BYTES_PER_LINE)
)
(
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           clk_en_i,
    input  logic           enabled_i,
    output logic [H_W-1:0] h_o,
    output logic           h_end_o,
    output logic           frame_end_o,
    output logic           efx_o,
    output logic           int_o,
    output logic           v_active_o,
    output logic           v_active_nxt_o
);

    localparam int unsigned V_W     = $clog2(LINES_PER_FRAME);
    localparam int unsigned ACT_END = ACTIVE_START + ACTIVE_LINES;

    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;
    logic           efx_q, int_q, vact_q;
    logic           h_end, v_end;
    logic           efx_nxt, int_nxt, vact_nxt;
    int unsigned    v32;

    assign h_end = (h_q == H_W'(BYTES_PER_LINE - 1));
    assign v_end = (v_q == V_W'(LINES_PER_FRAME - 1));
    assign v32   = 32'(v_q);

    always_comb begin
        h_d = h_end ? '0 : h_q + H_W'(1);
        v_d = v_q;
        if (h_end) begin
            v_d = v_end ? '0 : v_q + V_W'(1);
        end
    end

    // Windows are evaluated on the current line, one line ahead of their effect.
    always_comb begin
        efx_nxt  = in_window(v32, ACTIVE_START - EFX_LINES - 1, ACTIVE_START - 1)
                || in_window(v32, ACT_END - EFX_LINES - 1, ACT_END - 1);
        int_nxt  = enabled_i && in_window(v32, ACTIVE_START - INT_LINES - 1, ACTIVE_START - 1);
        vact_nxt = enabled_i && in_window(v32, ACTIVE_START - 1, ACT_END - 1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q    <= '0;
            v_q    <= '0;
            efx_q  <= 1'b0;
            int_q  <= 1'b0;
            vact_q <= 1'b0;
        end else if (clk_en_i) begin
            h_q <= h_d;
            v_q <= v_d;
            if (h_end) begin
                efx_q  <= efx_nxt;
                int_q  <= int_nxt;
                vact_q <= vact_nxt;
            end
        end
    end

    assign h_o            = h_q;
    assign h_end_o        = h_end;
    assign frame_end_o    = h_end && v_end;
    assign efx_o          = efx_q;
    assign int_o          = int_q;
    assign v_active_o     = vact_q;
    assign v_active_nxt_o = vact_nxt;

endmodule

// File: rtl/pixie_dma_engine.sv
// CDP1861-style video DMA front end: DMA request timing, display buffer write path
// with hardware line repeat, frame-start strobe and sticky underrun status.
module pixie_dma_engine
    import pixie_pkg::*;
#(
    parameter int unsigned BYTES_PER_LINE  = 14,
    parameter int unsigned LINES_PER_FRAME = 262,
    parameter int unsigned ACTIVE_START    = 80,
    parameter int unsigned ACTIVE_LINES    = 128,
    parameter int unsigned INT_LINES       = 2,
    parameter int unsigned EFX_LINES       = 4,
    parameter int unsigned DMA_FIRST       = 1,
    parameter int unsigned DMA_BYTES       = 8,
    parameter int unsigned ADDR_W          = 10
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_enable,
    input  logic [1:0]        sc,
    input  logic              disp_on,
    input  logic              disp_off,
    input  logic [1:0]        line_rep,
    input  logic [7:0]        data,
    output logic              dmao,
    output logic              int_pixie,
    output logic              efx,
    output logic              frame_start,
    output logic              underrun,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wr_en
);

    localparam int unsigned H_W   = $clog2(BYTES_PER_LINE);
    localparam int unsigned CNT_W = $clog2(DMA_BYTES + 1);

    rep_state_e         state_q;
    logic               enabled_q, enabled_d, en_now;
    logic [ADDR_W-1:0]  addr_q, line_base_q, addr_inc;
    logic [REP_W-1:0]   rep_cnt_q, rep_last_q;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_inc;
    logic               underrun_q, frame_start_q;
    logic               wr;

    logic [H_W-1:0]     h;
    logic               h_end, frame_end, v_active, v_active_nxt;

    pixie_timing_gen #(
        .BYTES_PER_LINE  (BYTES_PER_LINE),
        .LINES_PER_FRAME (LINES_PER_FRAME),
        .ACTIVE_START    (ACTIVE_START),
        .ACTIVE_LINES    (ACTIVE_LINES),
        .INT_LINES       (INT_LINES),
        .EFX_LINES       (EFX_LINES)
    ) u_timing (
        .clk_i          (clk),
        .rst_ni         (reset_n),
        .clk_en_i       (clk_enable),
        .enabled_i      (enabled_q),
        .h_o            (h),
        .h_end_o        (h_end),
        .frame_end_o    (frame_end),
        .efx_o          (efx),
        .int_o          (int_pixie),
        .v_active_o     (v_active),
        .v_active_nxt_o (v_active_nxt)
    );

    // en_now lets a qualified disp_off remove dmao within the same machine cycle.
    assign enabled_d = disp_on | (enabled_q & ~disp_off);
    assign en_now    = clk_enable ? enabled_d : enabled_q;

    assign dmao      = en_now && v_active
                    && in_window(32'(h), DMA_FIRST, DMA_FIRST + DMA_BYTES);
    assign mem_wr_en = enabled_q && (sc == SC_DMA);
    assign mem_addr  = addr_q;
    assign mem_data  = data;
    assign wr        = mem_wr_en && clk_enable;

    assign addr_inc   = wr ? addr_q + ADDR_W'(1) : addr_q;
    assign wr_cnt_inc = (wr && (wr_cnt_q != CNT_W'(DMA_BYTES))) ? wr_cnt_q + CNT_W'(1) : wr_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_OFF;
            enabled_q     <= 1'b0;
            addr_q        <= '0;
            line_base_q   <= '0;
            rep_cnt_q     <= '0;
            rep_last_q    <= '0;
            wr_cnt_q      <= '0;
            underrun_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (clk_enable) begin
            enabled_q     <= enabled_d;
            frame_start_q <= frame_end;
            wr_cnt_q      <= h_end ? '0 : wr_cnt_inc;

            if (disp_on) begin
                underrun_q <= 1'b0;
            end else if (h_end && v_active && enabled_q && (32'(wr_cnt_inc) < DMA_BYTES)) begin
                underrun_q <= 1'b1;
            end

            if (state_q != ST_OFF) begin
                addr_q <= addr_inc;
            end

            // Rewind at line end overrides the address increment assigned above.
            case (state_q)
                ST_OFF: begin
                    if (enabled_q) state_q <= ST_BLANK;
                end
                ST_BLANK: begin
                    if (h_end && v_active_nxt) begin
                        state_q     <= ST_FETCH;
                        line_base_q <= addr_inc;
                        rep_cnt_q   <= '0;
                        rep_last_q  <= rep_last(line_rep);
                    end
                end
                ST_FETCH, ST_REPEAT: begin
                    if (h_end) begin
                        if (!v_active_nxt) begin
                            state_q <= ST_BLANK;
                        end else if (rep_cnt_q == rep_last_q) begin
                            state_q     <= ST_FETCH;
                            rep_cnt_q   <= '0;
                            line_base_q <= addr_inc;
                        end else begin
                            state_q   <= ST_REPEAT;
                            rep_cnt_q <= rep_cnt_q + REP_W'(1);
                            addr_q    <= line_base_q;
                        end
                    end
                end
                default: state_q <= ST_OFF;
            endcase

            if (!enabled_q) begin
                state_q <= ST_OFF;
            end

            if (frame_end) begin
                addr_q      <= '0;
                line_base_q <= '0;
                rep_cnt_q   <= '0;
            end
        end
    end

    assign underrun    = underrun_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_pixie_dma_engine.sv
// Directed bench for pixie_dma_engine at default geometry (14 x 262, active lines 80..207).
module tb_pixie_dma_engine;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clk_enable;
    logic [1:0] sc;
    logic       disp_on;
    logic       disp_off;
    logic [1:0] line_rep;
    logic [7:0] data;
    logic       dmao;
    logic       int_pixie;
    logic       efx;
    logic       frame_start;
    logic       underrun;
    logic [9:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_wr_en;

    int checks = 0;
    int errors = 0;

    int g_h, g_v;
    bit m_en, ack_on, in_act, do_ack, last_dmao;
    int rep, short_line, exp_a, last_addr;
    int n_dmao, n_dmao_bad, n_int, n_int_bad, n_efx, n_efx_bad, n_fs;
    int n_wr, n_addr_bad, n_data_bad;

    pixie_dma_engine #(
        .BYTES_PER_LINE  (14),
        .LINES_PER_FRAME (262),
        .ACTIVE_START    (80),
        .ACTIVE_LINES    (128),
        .INT_LINES       (2),
        .EFX_LINES       (4),
        .DMA_FIRST       (1),
        .DMA_BYTES       (8),
        .ADDR_W          (10)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_enable  (clk_enable),
        .sc          (sc),
        .disp_on     (disp_on),
        .disp_off    (disp_off),
        .line_rep    (line_rep),
        .data        (data),
        .dmao        (dmao),
        .int_pixie   (int_pixie),
        .efx         (efx),
        .frame_start (frame_start),
        .underrun    (underrun),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_wr_en   (mem_wr_en)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_counts();
        n_dmao = 0; n_dmao_bad = 0; n_int = 0; n_int_bad = 0; n_efx = 0; n_efx_bad = 0;
        n_fs = 0; n_wr = 0; n_addr_bad = 0; n_data_bad = 0; last_addr = -1;
    endtask

    // One machine cycle: advance the bench's h/v, drive the CPU ack, observe outputs.
    task automatic step_cycle();
        @(posedge clk);
        #1;
        disp_on  = 1'b0;
        disp_off = 1'b0;
        if (g_h == 13) begin
            g_h = 0;
            g_v = (g_v == 261) ? 0 : g_v + 1;
        end else begin
            g_h = g_h + 1;
        end
        in_act = m_en && g_v >= 80 && g_v <= 207 && g_h >= 1 && g_h <= 8;
        do_ack = ack_on && in_act && !(g_v == short_line && g_h > 6);
        sc     = do_ack ? 2'b10 : 2'b00;
        data   = 8'((g_v * 7 + g_h * 13) % 256);
        #1;
        last_dmao = dmao;
        if (dmao !== in_act) n_dmao_bad++;
        if (dmao === 1'b1) n_dmao++;
        if (int_pixie === 1'b1) begin
            n_int++;
            if (!(g_v == 78 || g_v == 79)) n_int_bad++;
        end
        if (efx === 1'b1) begin
            n_efx++;
            if (!((g_v >= 76 && g_v <= 79) || (g_v >= 204 && g_v <= 207))) n_efx_bad++;
        end
        if (frame_start === 1'b1) n_fs++;
        if (mem_wr_en === 1'b1) begin
            exp_a = (((n_wr / 8) / rep) * 8 + (n_wr % 8)) % 1024;
            if (mem_addr !== 10'(exp_a)) n_addr_bad++;
            if (mem_data !== data) n_data_bad++;
            last_addr = int'(mem_addr);
            n_wr++;
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    task automatic run_until(input int tv, input int th);
        int n;
        n = 0;
        while (!(g_v == tv && g_h == th) && n < 8000) begin
            step_cycle();
            n++;
        end
        if (!(g_v == tv && g_h == th)) begin
            checks++; errors++;
            $display("FAIL run_until_bound: got v=%0d h=%0d expected v=%0d h=%0d", g_v, g_h, tv, th);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clk_enable = 1'b0; sc = 2'b00; disp_on = 1'b0; disp_off = 1'b0;
        line_rep = 2'd0; data = 8'h00; m_en = 1'b0; ack_on = 1'b0; rep = 1; short_line = -1;
        clear_counts();
        #23;
        checks++;
        if ({dmao, int_pixie, efx, frame_start, underrun, mem_wr_en, mem_addr} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {dmao, int_pixie, efx, frame_start, underrun, mem_wr_en, mem_addr});
        end
        @(negedge clk);
        reset_n = 1'b1; clk_enable = 1'b1; g_h = 0; g_v = 0;
        disp_on = 1'b1; m_en = 1'b1; ack_on = 1'b1;
        run_until(82, 5);
        checks++;
        if (dmao !== 1'b1) begin errors++; $display("FAIL pre_reset_dmao: got %b expected 1", dmao); end
        checks++;
        if (mem_addr !== 10'd20) begin errors++; $display("FAIL pre_reset_addr: got %0d expected 20", mem_addr); end
        // Asynchronous reset with the machine-cycle enable low
        clk_enable = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({dmao, int_pixie, efx, frame_start, underrun, mem_wr_en, mem_addr} !== 16'h0000) begin
            errors++;
            $display("FAIL midframe_reset_outputs: got %b expected 0",
                     {dmao, int_pixie, efx, frame_start, underrun, mem_wr_en, mem_addr});
        end
        @(negedge clk);
        reset_n = 1'b1; sc = 2'b00; m_en = 1'b0; ack_on = 1'b0;
        @(negedge clk);
        clk_enable = 1'b1; g_h = 0; g_v = 0;
        run_until(75, 13);
        checks++;
        if (efx !== 1'b0) begin errors++; $display("FAIL restart_efx_line75: got %b expected 0", efx); end
        step_cycle();
        checks++;
        if (efx !== 1'b1) begin errors++; $display("FAIL restart_efx_line76: got %b expected 1", efx); end
        run_until(0, 0);
    endtask

    task automatic test_default();
        disp_on = 1'b1; m_en = 1'b1; ack_on = 1'b1; line_rep = 2'd0; rep = 1; short_line = -1;
        clear_counts();
        run_cycles(3668);
        checks++;
        if (n_int !== 28 || n_int_bad !== 0) begin
            errors++; $display("FAIL default_int: got %0d cycles (%0d misplaced) expected 28 (0)", n_int, n_int_bad);
        end
        checks++;
        if (n_dmao !== 1024 || n_dmao_bad !== 0) begin
            errors++; $display("FAIL default_dmao: got %0d cycles (%0d wrong) expected 1024 (0)", n_dmao, n_dmao_bad);
        end
        checks++;
        if (n_wr !== 1024) begin errors++; $display("FAIL default_writes: got %0d expected 1024", n_wr); end
        checks++;
        if (n_addr_bad !== 0 || last_addr !== 1023) begin
            errors++; $display("FAIL default_addr_seq: got %0d bad, last %0d expected 0 bad, last 1023", n_addr_bad, last_addr);
        end
        checks++;
        if (n_data_bad !== 0) begin errors++; $display("FAIL default_mem_data: got %0d bad expected 0", n_data_bad); end
        checks++;
        if (n_fs !== 1) begin errors++; $display("FAIL default_frame_start: got %0d pulses expected 1", n_fs); end
        checks++;
        if (n_efx !== 112 || n_efx_bad !== 0) begin
            errors++; $display("FAIL default_efx: got %0d cycles (%0d misplaced) expected 112 (0)", n_efx, n_efx_bad);
        end
        checks++;
        if (mem_addr !== 10'd0) begin errors++; $display("FAIL default_addr_wrap: got %0d expected 0", mem_addr); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL default_underrun: got %b expected 0", underrun); end
    endtask

    task automatic test_line_repeat();
        line_rep = 2'd2; rep = 4;
        clear_counts();
        run_until(208, 0);
        checks++;
        if (mem_addr !== 10'd256) begin errors++; $display("FAIL rep4_end_addr: got %0d expected 256", mem_addr); end
        run_until(0, 0);
        checks++;
        if (n_wr !== 1024 || n_addr_bad !== 0) begin
            errors++; $display("FAIL rep4_addr_seq: got %0d writes %0d bad expected 1024 writes 0 bad", n_wr, n_addr_bad);
        end
        checks++;
        if (last_addr !== 255) begin errors++; $display("FAIL rep4_last_addr: got %0d expected 255", last_addr); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL rep4_underrun: got %b expected 0", underrun); end
        checks++;
        if (mem_addr !== 10'd0) begin errors++; $display("FAIL rep4_frame_wrap: got %0d expected 0", mem_addr); end
    endtask

    task automatic test_underrun();
        line_rep = 2'd0; rep = 1; short_line = 90;
        clear_counts();
        run_until(90, 13);
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_before: got %b expected 0", underrun); end
        step_cycle();
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set: got %b expected 1", underrun); end
        run_until(0, 0);
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b expected 1", underrun); end
        short_line = -1;
        disp_on = 1'b1;
        step_cycle();
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear: got %b expected 0", underrun); end
    endtask

    task automatic test_disp_off();
        run_until(100, 4);
        checks++;
        if (last_dmao !== 1'b1) begin errors++; $display("FAIL disp_off_dmao_before: got %b expected 1", last_dmao); end
        disp_off = 1'b1; sc = 2'b00; m_en = 1'b0;
        #1;
        checks++;
        if (dmao !== 1'b0) begin errors++; $display("FAIL disp_off_same_cycle: got %b expected 0", dmao); end
        clear_counts();
        run_until(0, 0);
        run_cycles(3668);
        checks++;
        if (n_int !== 0) begin errors++; $display("FAIL disp_off_int: got %0d cycles expected 0", n_int); end
        checks++;
        if (n_dmao !== 0 || n_wr !== 0) begin
            errors++; $display("FAIL disp_off_dma: got %0d dmao %0d writes expected 0 0", n_dmao, n_wr);
        end
        checks++;
        if (n_efx !== 168 || n_efx_bad !== 0) begin
            errors++; $display("FAIL disp_off_efx: got %0d cycles (%0d misplaced) expected 168 (0)", n_efx, n_efx_bad);
        end
    endtask

    task automatic test_on_off_same_cycle();
        disp_on = 1'b1; disp_off = 1'b1; m_en = 1'b1; ack_on = 1'b1; rep = 1;
        clear_counts();
        run_cycles(3668);
        checks++;
        if (n_int !== 28) begin errors++; $display("FAIL both_strobes_int: got %0d cycles expected 28", n_int); end
        checks++;
        if (n_dmao !== 1024 || n_dmao_bad !== 0) begin
            errors++; $display("FAIL both_strobes_dmao: got %0d (%0d wrong) expected 1024 (0)", n_dmao, n_dmao_bad);
        end
        checks++;
        if (n_wr !== 1024 || n_addr_bad !== 0) begin
            errors++; $display("FAIL both_strobes_writes: got %0d writes %0d bad expected 1024 0", n_wr, n_addr_bad);
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_line_repeat();
        test_underrun();
        test_disp_off();
        test_on_off_same_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
